// File: rtl/lift_pkg.sv
// Shared definitions for the lift motion controller: FSM encoding, motor codes
// and default sizing.
package lift_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR      = 2'd3
  } state_e;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  localparam int DEF_NUM_FLOORS    = 11;
  localparam int DEF_TRAVEL_CYCLES = 8;
  localparam int DEF_DOOR_CYCLES   = 16;

  // Width of a down-counter that must hold n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/door_timer.sv
// Door-open countdown: loaded on door entry, reloaded while held, frozen on
// emergency stop, and flags expiry in the cycle the door may close.
module door_timer
  import lift_pkg::*;
#(
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  input  logic i_hold,
  input  logic i_freeze,
  output logic o_expire
);

  localparam int             CW   = cnt_w(DOOR_CYCLES);
  localparam logic [CW-1:0]  LOAD = CW'(DOOR_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_en && !i_load && !i_hold && !i_freeze && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_load || (i_en && i_hold))
      r_cnt <= LOAD;
    else if (i_en && !i_freeze && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

endmodule

// File: rtl/lift_motion_ctrl.sv
// Single-car lift motion controller: accepts one target at a time, steps the
// car floor by floor, then holds the door open before taking the next target.
module lift_motion_ctrl
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tgt_valid,
  input  logic [3:0] tgt_floor,
  output logic       tgt_ready,
  input  logic       door_hold,
  input  logic       estop,
  output logic [1:0] motor_signal,
  output logic [3:0] cur_floor,
  output logic       door_open,
  output logic       arrived,
  output logic       tgt_err
);

  localparam int             TCW         = cnt_w(TRAVEL_CYCLES);
  localparam logic [TCW-1:0] TRAVEL_LOAD = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [4:0]     FLOORS      = 5'(NUM_FLOORS);

  state_e         r_state, w_state;
  logic [3:0]     r_floor, w_floor, r_target, w_target, w_step_floor;
  logic [TCW-1:0] r_travel, w_travel;
  logic [1:0]     r_motor, w_motor;
  logic           r_door_open, w_door_open, r_arrived, w_arrived;
  logic           r_tgt_err, w_tgt_err, r_tgt_ready, w_tgt_ready;
  logic           w_door_load, w_door_expire;

  assign w_step_floor = (r_state == S_MOVE_UP) ? r_floor + 4'd1 : r_floor - 4'd1;

  door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_door (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_door_load),
    .i_en    (r_state == S_DOOR),
    .i_hold  (door_hold),
    .i_freeze(estop),
    .o_expire(w_door_expire)
  );

  always_comb begin
    w_state     = r_state;
    w_floor     = r_floor;
    w_target    = r_target;
    w_travel    = r_travel;
    w_motor     = r_motor;
    w_door_open = r_door_open;
    w_arrived   = 1'b0;
    w_tgt_err   = 1'b0;
    w_door_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tgt_valid && r_tgt_ready) begin
          if ({1'b0, tgt_floor} >= FLOORS) begin
            w_tgt_err = 1'b1;
          end else if (tgt_floor == r_floor) begin
            w_state     = S_DOOR;
            w_door_open = 1'b1;
            w_arrived   = 1'b1;
            w_door_load = 1'b1;
          end else begin
            w_target = tgt_floor;
            w_travel = TRAVEL_LOAD;
            w_state  = (tgt_floor > r_floor) ? S_MOVE_UP : S_MOVE_DOWN;
            w_motor  = (tgt_floor > r_floor) ? MOTOR_UP : MOTOR_DOWN;
          end
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        // Emergency stop parks the motor but keeps the travel count intact.
        if (estop) begin
          w_motor = MOTOR_STOP;
        end else begin
          w_motor = (r_state == S_MOVE_UP) ? MOTOR_UP : MOTOR_DOWN;
          if (r_travel == '0) begin
            w_floor = w_step_floor;
            if (w_step_floor == r_target) begin
              w_state     = S_DOOR;
              w_motor     = MOTOR_STOP;
              w_door_open = 1'b1;
              w_arrived   = 1'b1;
              w_door_load = 1'b1;
            end else begin
              w_travel = TRAVEL_LOAD;
            end
          end else begin
            w_travel = r_travel - 1'b1;
          end
        end
      end
      S_DOOR: begin
        w_motor = MOTOR_STOP;
        if (w_door_expire) begin
          w_state     = S_IDLE;
          w_door_open = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_tgt_ready = (w_state == S_IDLE) && !estop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_floor     <= '0;
      r_target    <= '0;
      r_travel    <= '0;
      r_motor     <= MOTOR_STOP;
      r_door_open <= 1'b0;
      r_arrived   <= 1'b0;
      r_tgt_err   <= 1'b0;
      r_tgt_ready <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_floor     <= w_floor;
      r_target    <= w_target;
      r_travel    <= w_travel;
      r_motor     <= w_motor;
      r_door_open <= w_door_open;
      r_arrived   <= w_arrived;
      r_tgt_err   <= w_tgt_err;
      r_tgt_ready <= w_tgt_ready;
    end
  end

  assign tgt_ready    = r_tgt_ready;
  assign motor_signal = r_motor;
  assign cur_floor    = r_floor;
  assign door_open    = r_door_open;
  assign arrived      = r_arrived;
  assign tgt_err      = r_tgt_err;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Bench for lift_motion_ctrl: a table of directed trips, hand sequences for
// estop / reset corners, and random trips checked against a floor-position model.
module tb_lift_motion_ctrl;

  localparam int NF = 11;
  localparam int TC = 8;
  localparam int DC = 16;

  logic       clk = 1'b0, rst = 1'b0;
  logic       tgt_valid = 1'b0, door_hold = 1'b0, estop = 1'b0;
  logic [3:0] tgt_floor = 4'd0;
  logic       tgt_ready, door_open, arrived, tgt_err;
  logic [1:0] motor_signal;
  logic [3:0] cur_floor;

  int n_cmp = 0, n_fail = 0;
  int m_floor = 0, last_lat = 0, last_door = 0, last_err = 0;

  always #5 clk = ~clk;

  lift_motion_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_floor(tgt_floor),
    .tgt_ready(tgt_ready), .door_hold(door_hold), .estop(estop),
    .motor_signal(motor_signal), .cur_floor(cur_floor), .door_open(door_open),
    .arrived(arrived), .tgt_err(tgt_err)
  );

  typedef struct {
    int tgt; int es; int el; int hs; int hl; int dfrz;
    int err; int lat; int floor; int door;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One trip: wait for ready, offer tgt, follow the car edge by edge. Position
  // model: floor = start + dir * (unfrozen edges since acceptance / TC).
  task automatic trip(input int tgt, input int es, input int el, input int hs,
                      input int hl, input int dfrz, input int pct);
    int d, dir, goal, a, k, n, g, dcode;
    logic sv, win;
    g = 0;
    while (tgt_ready !== 1'b1 && g < 200) begin tick(); g++; end
    chk("ready_wait", int'(tgt_ready), 1);
    tgt_floor = 4'(tgt); tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    last_lat = 0; last_door = 0; last_err = int'(tgt_err);
    if (tgt >= NF) begin
      chk("err_pulse", int'(tgt_err), 1);
      chk("err_motor", int'(motor_signal), 0);
      chk("err_floor", int'(cur_floor), m_floor);
      chk("err_ready", int'(tgt_ready), 1);
      tick();
      chk("err_clear", int'(tgt_err), 0);
      return;
    end
    chk("no_err", int'(tgt_err), 0);
    d     = tgt - m_floor;
    dir   = (d > 0) ? 1 : -1;
    dcode = (d > 0) ? 1 : 2;
    goal  = ((d < 0) ? -d : d) * TC;
    a = 0; k = 0; last_lat = 1;
    while (a < goal && k < 2000) begin
      k++;
      sv = (k >= es && k < es + el) || (pct > 0 && int'($urandom_range(0, 99)) < pct);
      estop = sv;
      tick();
      last_lat++;
      if (!sv) a++;
      chk("floor", int'(cur_floor), m_floor + dir * (a / TC));
      chk("motor", int'(motor_signal), (a == goal) ? 0 : (sv ? 0 : dcode));
      chk("arrived", int'(arrived), int'(a == goal));
      chk("door_during_move", int'(door_open), int'(a == goal));
    end
    estop = 1'b0;
    chk("trip_bound", a, goal);
    chk("arr_pulse", int'(arrived), 1);
    chk("arr_door", int'(door_open), 1);
    chk("arr_motor", int'(motor_signal), 0);
    chk("arr_floor", int'(cur_floor), tgt);
    m_floor = tgt;
    n = 1;
    while (door_open === 1'b1 && n < 300) begin
      win = (n >= hs && n < hs + hl);
      door_hold = win && (dfrz == 0);
      estop     = win && (dfrz != 0);
      tick();
      if (door_open === 1'b1) n++;
      if (n == 2) chk("arr_once", int'(arrived), 0);
    end
    door_hold = 1'b0; estop = 1'b0;
    last_door = n;
    chk("ready_after_door", int'(tgt_ready), 1);
    chk("motor_idle", int'(motor_signal), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, prev, t;
    //            tgt es el hs hl frz err lat flr door
    tbl[0]  = '{ 3, 0, 0, 0, 0, 0, 0, 25, 3, 16};
    tbl[1]  = '{ 5, 0, 0, 0, 0, 0, 0, 17, 5, 16};
    tbl[2]  = '{ 2, 0, 0, 0, 0, 0, 0, 25, 2, 16};
    tbl[3]  = '{12, 0, 0, 0, 0, 0, 1,  0, 2,  0};
    tbl[4]  = '{15, 0, 0, 0, 0, 0, 1,  0, 2,  0};
    tbl[5]  = '{ 0, 0, 0, 0, 0, 0, 0, 17, 0, 16};
    tbl[6]  = '{ 0, 0, 0, 5,10, 0, 0,  1, 0, 30};
    tbl[7]  = '{ 1, 3, 5, 0, 0, 0, 0, 14, 1, 16};
    tbl[8]  = '{ 1, 0, 0, 5, 4, 1, 0,  1, 1, 20};
    tbl[9]  = '{10, 0, 0, 0, 0, 0, 0, 73,10, 16};
    tbl[10] = '{11, 0, 0, 0, 0, 0, 1,  0,10,  0};
    tbl[11] = '{10, 0, 0, 0, 0, 0, 0,  1,10, 16};
    tbl[12] = '{ 0, 0, 0, 0, 0, 0, 0, 81, 0, 16};

    #22;
    chk("rst_ready", int'(tgt_ready), 0);
    chk("rst_motor", int'(motor_signal), 0);
    chk("rst_floor", int'(cur_floor), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_arrived", int'(arrived), 0);
    chk("rst_err", int'(tgt_err), 0);
    rst = 1'b1;
    tick();
    chk("ready_first_edge", int'(tgt_ready), 1);

    for (int i = 0; i < 13; i++) begin
      trip(tbl[i].tgt, tbl[i].es, tbl[i].el, tbl[i].hs, tbl[i].hl, tbl[i].dfrz, 0);
      chk($sformatf("v%0d_err", i), last_err, tbl[i].err);
      chk($sformatf("v%0d_lat", i), last_lat, tbl[i].lat);
      chk($sformatf("v%0d_floor", i), int'(cur_floor), tbl[i].floor);
      chk($sformatf("v%0d_door", i), last_door, tbl[i].door);
    end

    // Estop in IDLE blocks acceptance.
    estop = 1'b1;
    tick();
    chk("estop_idle_ready", int'(tgt_ready), 0);
    tgt_floor = 4'd5; tgt_valid = 1'b1;
    tick(); tick();
    chk("estop_idle_motor", int'(motor_signal), 0);
    chk("estop_idle_floor", int'(cur_floor), m_floor);
    tgt_valid = 1'b0; estop = 1'b0;
    tick();
    chk("estop_idle_release", int'(tgt_ready), 1);

    // Asynchronous reset in the middle of an upward trip.
    tgt_floor = 4'd9; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    g = 0;
    while (cur_floor != 4'd6 && g < 200) begin tick(); g++; end
    chk("reach_floor6", int'(cur_floor), 6);
    chk("moving_before_rst", int'(motor_signal), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_floor", int'(cur_floor), 0);
    chk("async_rst_motor", int'(motor_signal), 0);
    chk("async_rst_ready", int'(tgt_ready), 0);
    chk("async_rst_door", int'(door_open), 0);
    #3 rst = 1'b1;
    tick();
    chk("post_rst_ready", int'(tgt_ready), 1);
    chk("post_rst_floor", int'(cur_floor), 0);
    m_floor = 0;

    for (int i = 0; i < 30; i++) begin
      prev = m_floor;
      t = int'($urandom_range(0, 13));
      trip(t, 0, 0, 0, 0, 0, 20);
      chk("rnd_floor", int'(cur_floor), (t < NF) ? t : prev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lift_motion_ctrl.md
LIFT_MOTION_CTRL -- requirements
Module: lift_motion_ctrl

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 11, number of served floors (0..NUM_FLOORS-1).
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 8, clock cycles to move one floor.
REQ-003 SHALL have parameter DOOR_CYCLES, default 16, clock cycles the door stays open.
REQ-004 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 tgt_valid  input  1  target floor offered by the lift dispatch stage.
REQ-008 tgt_floor  input  4  target floor number.
REQ-009 tgt_ready  output  1  controller can accept a target.
REQ-010 door_hold  input  1  door-open button / obstruction; extends door time.
REQ-011 estop  input  1  emergency stop; level-sensitive.
REQ-012 motor_signal  output  2  00 stop, 01 up, 10 down; 11 never driven.
REQ-013 cur_floor  output  4  current floor.
REQ-014 door_open  output  1  door open command.
REQ-015 arrived  output  1  one-cycle pulse on reaching the target.
REQ-016 tgt_err  output  1  one-cycle pulse when an out-of-range target is accepted.

Function
REQ-017 SHALL implement states IDLE, MOVE_UP, MOVE_DOWN, DOOR; all outputs registered.
REQ-018 tgt_ready SHALL be 1 only in IDLE; a target is accepted on a cycle with tgt_valid and tgt_ready both 1.
REQ-019 Accepted tgt_floor >= NUM_FLOORS: drop, pulse tgt_err next cycle, remain IDLE.
REQ-020 Accepted tgt_floor == cur_floor: next cycle enter DOOR, door_open=1, arrived pulse, motor 00.
REQ-021 Accepted tgt_floor > cur_floor: next cycle enter MOVE_UP, motor_signal=01; < cur_floor: MOVE_DOWN, motor_signal=10.
REQ-022 Travel counter loads TRAVEL_CYCLES-1 on entry to a move state and on each floor step; decrements each non-stopped cycle; at 0, cur_floor steps by +1 (up) or -1 (down).
REQ-023 The cycle cur_floor steps onto the target: next state DOOR, motor_signal=00, door_open=1, arrived=1 for that one cycle.
REQ-024 Travel latency: arrived asserts exactly |target-start| x TRAVEL_CYCLES cycles after the motor first leaves 00, absent estop.
REQ-025 cur_floor SHALL never leave 0..NUM_FLOORS-1; no wrap-around.
REQ-026 DOOR: door counter loads DOOR_CYCLES-1 on entry, decrements each cycle; at 0 with door_hold=0, door_open=0 and return to IDLE.
REQ-027 door_hold=1 in DOOR reloads door counter to DOOR_CYCLES-1 each cycle it is high.
REQ-028 estop=1 in a move state: motor_signal=00 next cycle, travel counter and cur_floor frozen; on estop=0 resume same direction with counter value unchanged.
REQ-029 estop=1 in IDLE: tgt_ready=0; in DOOR: door stays open, counter frozen.
REQ-030 tgt_valid and tgt_floor ignored outside IDLE; upstream holds the request until accepted.

Reset
REQ-031 On rst=0, immediately: state IDLE, cur_floor 0, motor_signal 00, door_open 0, arrived 0, tgt_err 0, tgt_ready 0, counters 0.
REQ-032 tgt_ready SHALL rise the first clock edge after rst deasserts; reset mid-move abandons the trip, cur_floor returns to 0.

Structure
REQ-033 Shared package lift_pkg SHALL hold the state encoding, motor codes (STOP/UP/DOWN) and default NUM_FLOORS, TRAVEL_CYCLES, DOOR_CYCLES.
REQ-034 Door timing SHALL be a sub-module door_timer (load, hold, freeze, expire pulse); travel counter stays in the top.

Verification
REQ-035 Reset, target 3 accepted at cycle 0 -> motor 01 cycle 1, cur_floor 3 and arrived at cycle 25, door_open cycles 25-40, tgt_ready again at 41.
REQ-036 From floor 5, target 2 -> motor 10, cur_floor 4,3,2 at 8-cycle spacing, arrived with cur_floor=2, motor 00 same cycle.
REQ-037 Target 12 (and 15) -> tgt_err pulse, no motor activity, cur_floor unchanged.
REQ-038 Target equal to cur_floor 0 -> no motion, door_open next cycle for 16 cycles; door_hold high 10 cycles mid-door extends closing by 10+ cycles.
REQ-039 estop for 5 cycles mid-floor during 0->1 trip -> motor 00 those cycles, arrival delayed by exactly 5 cycles.
REQ-040 rst asserted during MOVE_UP at floor 6 -> outputs reset asynchronously, cur_floor 0, tgt_ready 1 after release.
